// File: rtl/fifo_0_arb_pkg.sv
// Shared constants and FSM state type for the fifo_0 write-side arbiter.
package fifo_0_arb_pkg;
  localparam int N_SRC    = 4;
  localparam int SRC_W    = 2;
  localparam int DATA_W   = 7;
  localparam int FIFO_W   = 1 + SRC_W + DATA_W;
  localparam int LAST_BIT = 9;
  localparam int ID_LSB   = 7;
  localparam int DATA_LSB = 0;

  typedef enum logic {IDLE, BURST} arb_state_e;
endpackage

// File: rtl/fifo_0_rr_pick.sv
// Combinational round-robin picker: first requester at or after last_grant+1.
module fifo_0_rr_pick
  import fifo_0_arb_pkg::*;
(
  input  logic [N_SRC-1:0] req_i,
  input  logic [SRC_W-1:0] last_grant_i,
  output logic [SRC_W-1:0] pick_o,
  output logic             any_o
);

  logic [SRC_W-1:0] idx;

  // Scan from lowest to highest priority so the nearest requester overwrites last.
  always_comb begin
    pick_o = '0;
    idx    = '0;
    any_o  = |req_i;
    for (int k = N_SRC; k >= 1; k--) begin
      idx = last_grant_i + SRC_W'(k);
      if (req_i[idx]) pick_o = idx;
    end
  end

endmodule

// File: rtl/fifo_0_wr_arbiter.sv
// Packet-locked round-robin arbiter feeding the fifo_0 write port from four sources.
module fifo_0_wr_arbiter
  import fifo_0_arb_pkg::*;
#(
  parameter int LEN_W = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_SRC-1:0]        src_vld,
  input  logic [N_SRC-1:0]        src_last,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  output logic [N_SRC-1:0]        src_rdy,
  input  logic                    fifo_wr_vld,
  output logic                    fifo_wr_en,
  output logic [FIFO_W-1:0]       fifo_wr_data,
  output logic                    pkt_done,
  output logic [SRC_W-1:0]        pkt_src,
  output logic [LEN_W-1:0]        pkt_len
);

  arb_state_e       state_q;
  logic [SRC_W-1:0] grant_q, last_grant_q, pick;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             any_req, xfer;
  logic             pkt_done_q;
  logic [SRC_W-1:0] pkt_src_q;
  logic [LEN_W-1:0] pkt_len_q;
  logic [DATA_W-1:0] grant_data;

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    return (&v) ? v : v + LEN_W'(1);
  endfunction

  fifo_0_rr_pick u_pick (
    .req_i        (src_vld),
    .last_grant_i (last_grant_q),
    .pick_o       (pick),
    .any_o        (any_req)
  );

  // Transfers are suppressed while reset is held so nothing leaks into the FIFO.
  assign grant_data = src_data[int'(grant_q)*DATA_W +: DATA_W];
  assign xfer       = rst_n && (state_q == BURST) && src_vld[grant_q] && fifo_wr_vld;
  assign cnt_d      = sat_inc(cnt_q);

  always_comb begin
    src_rdy      = '0;
    fifo_wr_en   = xfer;
    fifo_wr_data = '0;
    if (xfer) begin
      src_rdy[grant_q]                     = 1'b1;
      fifo_wr_data[LAST_BIT]               = src_last[grant_q];
      fifo_wr_data[ID_LSB +: SRC_W]        = grant_q;
      fifo_wr_data[DATA_LSB +: DATA_W]     = grant_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= SRC_W'(N_SRC - 1);
      cnt_q        <= '0;
      pkt_done_q   <= 1'b0;
      pkt_src_q    <= '0;
      pkt_len_q    <= '0;
    end else begin
      pkt_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q <= pick;
            cnt_q   <= '0;
            state_q <= BURST;
          end
        end
        BURST: begin
          if (xfer) begin
            cnt_q <= cnt_d;
            if (src_last[grant_q]) begin
              state_q      <= IDLE;
              last_grant_q <= grant_q;
              pkt_done_q   <= 1'b1;
              pkt_src_q    <= grant_q;
              pkt_len_q    <= cnt_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pkt_done = pkt_done_q;
  assign pkt_src  = pkt_src_q;
  assign pkt_len  = pkt_len_q;

endmodule

// File: tb/tb_fifo_0_wr_arbiter.sv
// Directed bench for fifo_0_wr_arbiter: per-cycle vector table plus saturation and mid-burst reset sequences.
module tb_fifo_0_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  src_vld, src_last;
  logic [27:0] src_data;
  logic        fifo_wr_vld;

  logic [3:0]  rdy12, rdy4;
  logic        wen12, wen4;
  logic [9:0]  wd12, wd4;
  logic        done12, done4;
  logic [1:0]  psrc12, psrc4;
  logic [11:0] plen12;
  logic [3:0]  plen4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_0_wr_arbiter #(.LEN_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .src_vld(src_vld), .src_last(src_last), .src_data(src_data),
    .src_rdy(rdy12), .fifo_wr_vld(fifo_wr_vld), .fifo_wr_en(wen12), .fifo_wr_data(wd12),
    .pkt_done(done12), .pkt_src(psrc12), .pkt_len(plen12)
  );

  fifo_0_wr_arbiter #(.LEN_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .src_vld(src_vld), .src_last(src_last), .src_data(src_data),
    .src_rdy(rdy4), .fifo_wr_vld(fifo_wr_vld), .fifo_wr_en(wen4), .fifo_wr_data(wd4),
    .pkt_done(done4), .pkt_src(psrc4), .pkt_len(plen4)
  );

  typedef struct {
    logic        r;
    logic [3:0]  v, l;
    logic [27:0] d;
    logic        f;
    logic [3:0]  rdy;
    logic        we;
    logic [9:0]  wd;
    logic        dn;
    logic [1:0]  ps;
    logic [11:0] pl;
  } vec_t;

  vec_t tbl[$];

  localparam logic [27:0] DF = {7'h43, 7'h42, 7'h41, 7'h40};

  function automatic logic [27:0] sd(input logic [6:0] d3, d2, d1, d0);
    return {d3, d2, d1, d0};
  endfunction

  task automatic add(input logic r, input logic [3:0] v, input logic [3:0] l, input logic [27:0] d,
                     input logic f, input logic [3:0] rdy, input logic we, input logic [9:0] wd,
                     input logic dn, input logic [1:0] ps, input logic [11:0] pl);
    vec_t t;
    t.r = r; t.v = v; t.l = l; t.d = d; t.f = f;
    t.rdy = rdy; t.we = we; t.wd = wd; t.dn = dn; t.ps = ps; t.pl = pl;
    tbl.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] exp_wd;
    int wr_cnt;

    rst_n = 1'b0; src_vld = '0; src_last = '0; src_data = '0; fifo_wr_vld = 1'b1;
    next_cycle();

    // Reset with every source requesting, then release.
    for (int i = 0; i < 3; i++) add(0, 4'hF, 4'h0, DF, 1, 4'h0, 0, 10'h000, 0, 0, 0);
    add(1, 4'hF, 4'h0, DF, 1, 4'h0, 0, 10'h000, 0, 0, 0);
    // Round robin of 2-beat packets, wrapping back to source 0.
    add(1, 4'hF, 4'h0, DF, 1, 4'h1, 1, 10'h040, 0, 0, 0);
    add(1, 4'hF, 4'h1, DF, 1, 4'h1, 1, 10'h240, 0, 0, 0);
    add(1, 4'hF, 4'h0, DF, 1, 4'h0, 0, 10'h000, 1, 0, 2);
    add(1, 4'hF, 4'h0, DF, 1, 4'h2, 1, 10'h0C1, 0, 0, 2);
    add(1, 4'hF, 4'h2, DF, 1, 4'h2, 1, 10'h2C1, 0, 0, 2);
    add(1, 4'hF, 4'h0, DF, 1, 4'h0, 0, 10'h000, 1, 1, 2);
    add(1, 4'hF, 4'h0, DF, 1, 4'h4, 1, 10'h142, 0, 1, 2);
    add(1, 4'hF, 4'h4, DF, 1, 4'h4, 1, 10'h342, 0, 1, 2);
    add(1, 4'hF, 4'h0, DF, 1, 4'h0, 0, 10'h000, 1, 2, 2);
    add(1, 4'hF, 4'h0, DF, 1, 4'h8, 1, 10'h1C3, 0, 2, 2);
    add(1, 4'hF, 4'h8, DF, 1, 4'h8, 1, 10'h3C3, 0, 2, 2);
    add(1, 4'hF, 4'h0, DF, 1, 4'h0, 0, 10'h000, 1, 3, 2);
    add(1, 4'hF, 4'h0, DF, 1, 4'h1, 1, 10'h040, 0, 3, 2);
    add(1, 4'hF, 4'h1, DF, 1, 4'h1, 1, 10'h240, 0, 3, 2);
    add(1, 4'h0, 4'h0, DF, 1, 4'h0, 0, 10'h000, 1, 0, 2);
    // Source 1, five beats, FIFO full for three cycles after beat 2.
    add(1, 4'h2, 4'h0, sd(0, 0, 7'h11, 0), 1, 4'h0, 0, 10'h000, 0, 0, 2);
    add(1, 4'h2, 4'h0, sd(0, 0, 7'h11, 0), 1, 4'h2, 1, 10'h091, 0, 0, 2);
    add(1, 4'h2, 4'h0, sd(0, 0, 7'h12, 0), 1, 4'h2, 1, 10'h092, 0, 0, 2);
    for (int i = 0; i < 3; i++) add(1, 4'h2, 4'h0, sd(0, 0, 7'h13, 0), 0, 4'h0, 0, 10'h000, 0, 0, 2);
    add(1, 4'h2, 4'h0, sd(0, 0, 7'h13, 0), 1, 4'h2, 1, 10'h093, 0, 0, 2);
    add(1, 4'h2, 4'h0, sd(0, 0, 7'h14, 0), 1, 4'h2, 1, 10'h094, 0, 0, 2);
    add(1, 4'h2, 4'h2, sd(0, 0, 7'h15, 0), 1, 4'h2, 1, 10'h295, 0, 0, 2);
    add(1, 4'h0, 4'h0, DF, 1, 4'h0, 0, 10'h000, 1, 1, 5);
    // Source 2 stalls mid-packet while source 3 waits; then a single-beat packet from source 3.
    add(1, 4'hC, 4'h0, sd(7'h33, 7'h22, 0, 0), 1, 4'h0, 0, 10'h000, 0, 1, 5);
    add(1, 4'hC, 4'h0, sd(7'h33, 7'h22, 0, 0), 1, 4'h4, 1, 10'h122, 0, 1, 5);
    for (int i = 0; i < 4; i++) add(1, 4'h8, 4'h0, sd(7'h33, 7'h22, 0, 0), 1, 4'h0, 0, 10'h000, 0, 1, 5);
    add(1, 4'hC, 4'h4, sd(7'h33, 7'h22, 0, 0), 1, 4'h4, 1, 10'h322, 0, 1, 5);
    add(1, 4'h8, 4'h0, sd(7'h33, 7'h22, 0, 0), 1, 4'h0, 0, 10'h000, 1, 2, 2);
    add(1, 4'h8, 4'h8, sd(7'h33, 7'h22, 0, 0), 1, 4'h8, 1, 10'h3B3, 0, 2, 2);
    add(1, 4'h0, 4'h0, DF, 1, 4'h0, 0, 10'h000, 1, 3, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      rst_n = tbl[i].r; src_vld = tbl[i].v; src_last = tbl[i].l;
      src_data = tbl[i].d; fifo_wr_vld = tbl[i].f;
      #1;
      chk($sformatf("v%0d_rdy", i), 32'(rdy12), 32'(tbl[i].rdy));
      chk($sformatf("v%0d_wen", i), 32'(wen12), 32'(tbl[i].we));
      chk($sformatf("v%0d_wdata", i), 32'(wd12), 32'(tbl[i].wd));
      chk($sformatf("v%0d_done", i), 32'(done12), 32'(tbl[i].dn));
      chk($sformatf("v%0d_psrc", i), 32'(psrc12), 32'(tbl[i].ps));
      chk($sformatf("v%0d_plen", i), 32'(plen12), 32'(tbl[i].pl));
      chk($sformatf("v%0d_plen4", i), 32'(plen4), 32'(tbl[i].pl[3:0]));
      @(posedge clk);
      #1;
    end

    // 20-beat packet from source 0: 12-bit counter shows 20, 4-bit counter saturates at 15.
    src_vld = 4'h1; src_last = 4'h0; src_data = '0; fifo_wr_vld = 1'b1; wr_cnt = 0;
    #1;
    chk("sat_idle_wen", 32'(wen12), 32'd0);
    next_cycle();
    for (int b = 1; b <= 20; b++) begin
      src_data = 28'(b);
      src_last = (b == 20) ? 4'h1 : 4'h0;
      #1;
      exp_wd = {(b == 20) ? 1'b1 : 1'b0, 2'b00, 7'(b)};
      chk($sformatf("sat_b%0d_wdata", b), 32'(wd12), 32'(exp_wd));
      if (wen4) wr_cnt++;
      next_cycle();
    end
    src_vld = 4'h0; src_last = 4'h0;
    #1;
    chk("sat_writes4", 32'(wr_cnt), 32'd20);
    chk("sat_done", 32'(done12), 32'd1);
    chk("sat_done4", 32'(done4), 32'd1);
    chk("sat_plen12", 32'(plen12), 32'd20);
    chk("sat_plen4", 32'(plen4), 32'd15);
    chk("sat_psrc", 32'(psrc4), 32'd0);
    next_cycle();

    // Reset after beat 3 of a source-1 packet; afterwards source 0 must win over source 1.
    src_vld = 4'h2; src_data = sd(0, 0, 7'h5A, 7'h05);
    next_cycle();
    for (int b = 1; b <= 3; b++) begin
      #1;
      chk($sformatf("mid_b%0d_rdy", b), 32'(rdy12), 32'h2);
      next_cycle();
    end
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("mid_rst%0d_rdy", c), 32'(rdy12), 32'h0);
      chk($sformatf("mid_rst%0d_wen", c), 32'(wen12), 32'h0);
      chk($sformatf("mid_rst%0d_wdata", c), 32'(wd12), 32'h0);
      next_cycle();
      chk($sformatf("mid_rst%0d_done", c), 32'(done12), 32'h0);
      chk($sformatf("mid_rst%0d_plen", c), 32'(plen12), 32'h0);
    end
    rst_n = 1'b1; src_vld = 4'h3;
    #1;
    chk("mid_rel_wen", 32'(wen12), 32'h0);
    next_cycle();
    chk("mid_rel_rdy", 32'(rdy12), 32'h1);
    chk("mid_rel_wdata", 32'(wd12), 32'h005);
    chk("mid_rel_done", 32'(done12), 32'h0);
    src_vld = 4'h0;
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
